// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters; EX-side mispredict/redirect.
// Optional statistics counters enabled by defining BP_STATS_EN.
module branch_predictor #(
    parameter int unsigned ADR_WIDTH  = 32,
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADR_WIDTH-1:0] i_pc,
    output logic                 o_hit,
    output logic                 o_taken,
    output logic [ADR_WIDTH-1:0] o_target,
    input  logic                 upd_valid,
    input  logic [ADR_WIDTH-1:0] upd_pc,
    input  logic                 upd_taken,
    input  logic [ADR_WIDTH-1:0] upd_target,
    input  logic                 upd_pred_taken,
    input  logic [ADR_WIDTH-1:0] upd_pred_target,
    output logic                 o_mispredict,
    output logic [ADR_WIDTH-1:0] o_redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] o_stat_updates,
    output logic [STAT_WIDTH-1:0] o_stat_mispredicts
`endif
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADR_WIDTH - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);

    logic [ENTRIES-1:0]   valid_q;
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [ADR_WIDTH-1:0] target_q [ENTRIES];
    logic [CTR_BITS-1:0]  ctr_q    [ENTRIES];

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX-1:0]   up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             pc_lsb_unused;

    assign lk_idx        = i_pc[IDX+1:2];
    assign lk_tag        = i_pc[ADR_WIDTH-1:IDX+2];
    assign up_idx        = upd_pc[IDX+1:2];
    assign up_tag        = upd_pc[ADR_WIDTH-1:IDX+2];
    assign up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign pc_lsb_unused = ^i_pc[1:0];

    // Lookup sees only pre-edge table contents; reset masks everything.
    always_comb begin
        o_hit    = 1'b0;
        o_taken  = 1'b0;
        o_target = '0;
        if (!rst && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)) begin
            o_hit    = 1'b1;
            o_taken  = ctr_q[lk_idx][CTR_BITS-1];
            o_target = target_q[lk_idx];
        end
    end

    always_comb begin
        o_mispredict  = 1'b0;
        o_redirect_pc = upd_taken ? upd_target : upd_pc + ADR_WIDTH'(4);
        if (!rst && upd_valid) begin
            o_mispredict = (upd_taken != upd_pred_taken) ||
                           (upd_taken && (upd_target != upd_pred_target));
        end
    end

    // Valid bits are the only table state cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (upd_valid && upd_taken && !up_hit) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    target_q[up_idx] <= upd_target;
                    if (ctr_q[up_idx] != CTR_MAX) begin
                        ctr_q[up_idx] <= ctr_q[up_idx] + CTR_BITS'(1);
                    end
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_q[up_idx] <= ctr_q[up_idx] - CTR_BITS'(1);
                end
            end else if (upd_taken) begin
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                ctr_q[up_idx]    <= CTR_INIT;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_stat_updates     <= '0;
            o_stat_mispredicts <= '0;
        end else begin
            if (upd_valid) begin
                o_stat_updates <= o_stat_updates + STAT_WIDTH'(1);
            end
            if (o_mispredict) begin
                o_stat_mispredicts <= o_stat_mispredicts + STAT_WIDTH'(1);
            end
        end
    end
`else
    localparam int unsigned STAT_WIDTH_UNUSED = STAT_WIDTH;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed cycles push expectations,
// a negedge monitor pops and compares against the live outputs.
module tb_branch_predictor;

    localparam int unsigned AW = 32;

    localparam logic [3:0] S_HIT   = 4'd0;
    localparam logic [3:0] S_TAKEN = 4'd1;
    localparam logic [3:0] S_TGT   = 4'd2;
    localparam logic [3:0] S_MISP  = 4'd3;
    localparam logic [3:0] S_REDIR = 4'd4;
    localparam logic [3:0] S_SUPD  = 4'd5;
    localparam logic [3:0] S_SMISP = 4'd6;

    typedef struct packed {
        logic [15:0] step;
        logic [3:0]  sel;
        logic [31:0] val;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] i_pc;
    logic          o_hit;
    logic          o_taken;
    logic [AW-1:0] o_target;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic          upd_taken;
    logic [AW-1:0] upd_target;
    logic          upd_pred_taken;
    logic [AW-1:0] upd_pred_target;
    logic          o_mispredict;
    logic [AW-1:0] o_redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0]   o_stat_updates;
    logic [31:0]   o_stat_mispredicts;
`endif

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step     = 0;

    branch_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .i_pc            (i_pc),
        .o_hit           (o_hit),
        .o_taken         (o_taken),
        .o_target        (o_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .o_mispredict    (o_mispredict),
        .o_redirect_pc   (o_redirect_pc)
`ifdef BP_STATS_EN
        ,
        .o_stat_updates     (o_stat_updates),
        .o_stat_mispredicts (o_stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string sel_name(input logic [3:0] sel);
        case (sel)
            S_HIT:   return "hit";
            S_TAKEN: return "taken";
            S_TGT:   return "target";
            S_MISP:  return "mispredict";
            S_REDIR: return "redirect_pc";
            S_SUPD:  return "stat_updates";
            default: return "stat_mispredicts";
        endcase
    endfunction

    function automatic logic [31:0] actual(input logic [3:0] sel);
        case (sel)
            S_HIT:   return 32'(o_hit);
            S_TAKEN: return 32'(o_taken);
            S_TGT:   return o_target;
            S_MISP:  return 32'(o_mispredict);
            S_REDIR: return o_redirect_pc;
`ifdef BP_STATS_EN
            S_SUPD:  return o_stat_updates;
            S_SMISP: return o_stat_mispredicts;
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: outputs are combinational, so every expectation for the
    // current cycle is valid at the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = exp_q.pop_front();
            a = actual(e.sel);
            checks++;
            if (a !== e.val) begin
                failures++;
                $display("FAIL step%0d %s actual=0x%08h expected=0x%08h",
                         e.step, sel_name(e.sel), a, e.val);
            end
        end
    end

    task automatic expect_val(input logic [3:0] sel, input logic [31:0] val);
        exp_q.push_back('{step: 16'(step), sel: sel, val: val});
    endtask

    task automatic set_in(input logic r, input logic [31:0] pc,
                          input logic uv, input logic [31:0] upc,
                          input logic ut, input logic [31:0] utgt,
                          input logic upt, input logic [31:0] uptgt);
        step++;
        rst             = r;
        i_pc            = pc;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utgt;
        upd_pred_taken  = upt;
        upd_pred_target = uptgt;
    endtask

    task automatic lookup_only(input logic [31:0] pc);
        set_in(1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic expect_lookup(input logic h, input logic t, input logic [31:0] tgt);
        expect_val(S_HIT, 32'(h));
        expect_val(S_TAKEN, 32'(t));
        expect_val(S_TGT, tgt);
    endtask

    task automatic expect_upd(input logic m, input logic [31:0] redir);
        expect_val(S_MISP, 32'(m));
        expect_val(S_REDIR, redir);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_in(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        // Reset with an update present: outputs masked, nothing written
        set_in(1'b1, 32'h0040_0020, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
        expect_lookup(1'b0, 1'b0, 32'h0);
        expect_val(S_MISP, 32'h0);
        tick();
        lookup_only(32'h0040_0010);
        expect_lookup(1'b0, 1'b0, 32'h0);
        tick();
        lookup_only(32'h0040_0020);
        expect_lookup(1'b0, 1'b0, 32'h0);
        tick();
        // Allocate on taken miss; lookup same cycle still misses
        set_in(1'b0, 32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
        expect_upd(1'b1, 32'h0040_0040);
        expect_lookup(1'b0, 1'b0, 32'h0);
        tick();
        lookup_only(32'h0040_0010);
        expect_lookup(1'b1, 1'b1, 32'h0040_0040);
        tick();
        // ctr 10 -> 01
        set_in(1'b0, 32'h0040_0010, 1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0040);
        expect_upd(1'b1, 32'h0040_0014);
        tick();
        lookup_only(32'h0040_0010);
        expect_lookup(1'b1, 1'b0, 32'h0040_0040);
        tick();
        // ctr 01 -> 00, then held at 00
        set_in(1'b0, 32'h0040_0010, 1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_upd(1'b0, 32'h0040_0014);
        tick();
        set_in(1'b0, 32'h0040_0010, 1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_upd(1'b0, 32'h0040_0014);
        expect_lookup(1'b1, 1'b0, 32'h0040_0040);
        tick();
        // Four taken hits: 00->01->10->11->11; lookup reads pre-edge counter
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040,
                   1'b1, 32'h0040_0040);
            expect_upd(1'b0, 32'h0040_0040);
            expect_val(S_TAKEN, (i >= 2) ? 32'h1 : 32'h0);
            tick();
        end
        // ctr 11 -> 10
        set_in(1'b0, 32'h0040_0010, 1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0040);
        expect_upd(1'b1, 32'h0040_0014);
        expect_val(S_TAKEN, 32'h1);
        tick();
        // Direction right, target wrong
        set_in(1'b0, 32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040,
               1'b1, 32'h0040_0044);
        expect_upd(1'b1, 32'h0040_0040);
        expect_lookup(1'b1, 1'b1, 32'h0040_0040);
        tick();
        // Alias into index 4 replaces the old entry
        set_in(1'b0, 32'h0040_0010, 1'b1, 32'h0040_0050, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
        expect_upd(1'b1, 32'h0040_0100);
        expect_lookup(1'b1, 1'b1, 32'h0040_0040);
        tick();
        set_in(1'b0, 32'h0040_0010, 1'b1, 32'h0040_0090, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_upd(1'b0, 32'h0040_0094);
        expect_lookup(1'b0, 1'b0, 32'h0);
        tick();
        lookup_only(32'h0040_0050);
        expect_lookup(1'b1, 1'b1, 32'h0040_0100);
        tick();
        lookup_only(32'h0040_0090);
        expect_lookup(1'b0, 1'b0, 32'h0);
        tick();
        // Same-cycle lookup and allocate of index 8
        set_in(1'b0, 32'h0040_0020, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0200,
               1'b1, 32'h0040_0200);
        expect_upd(1'b0, 32'h0040_0200);
        expect_lookup(1'b0, 1'b0, 32'h0);
        tick();
        lookup_only(32'h0040_0020);
        expect_lookup(1'b1, 1'b1, 32'h0040_0200);
        tick();
        // Fall-through redirect wraps at the top of the address space
        set_in(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_upd(1'b0, 32'h0000_0000);
        tick();
        lookup_only(32'h0040_0050);
        expect_lookup(1'b1, 1'b1, 32'h0040_0100);
`ifdef BP_STATS_EN
        expect_val(S_SUPD, 32'd14);
        expect_val(S_SMISP, 32'd5);
`endif
        tick();
        // Reset wins over a would-be mispredicting allocate
        set_in(1'b1, 32'h0040_0050, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0300, 1'b0, 32'h0);
        expect_lookup(1'b0, 1'b0, 32'h0);
        expect_val(S_MISP, 32'h0);
        tick();
        lookup_only(32'h0040_0050);
        expect_lookup(1'b0, 1'b0, 32'h0);
`ifdef BP_STATS_EN
        expect_val(S_SUPD, 32'd0);
        expect_val(S_SMISP, 32'd0);
`endif
        tick();
        lookup_only(32'h0040_0020);
        expect_lookup(1'b0, 1'b0, 32'h0);
        tick();
        lookup_only(32'h0040_0010);
        expect_lookup(1'b0, 1'b0, 32'h0);
        tick();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
